// File: rtl/swap_seq_ctrl_pkg.sv
// Shared definitions for the register-swap sequencer: FSM encoding, sizes, requester ids.
// Pure declarations; no timing or flow-control behaviour of its own.
package swap_seq_ctrl_pkg;

  localparam int NREG_DEF = 16;
  localparam int AW_DEF   = 4;

  localparam int REQ_CU  = 0;
  localparam int REQ_DMA = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAVE    = 3'd1,
    MOVE    = 3'd2,
    RESTORE = 3'd3,
    DONE    = 3'd4
  } state_t;

  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/swap_seq_ctrl_arb.sv
// Two-way round-robin arbiter: the requester not granted last wins a tie.
// Combinational, zero latency; no backpressure (the caller samples it only in IDLE).
module rr_arb2
  import swap_seq_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    gnt     = 2'b00;
    gnt_idx = 1'b0;
    unique case (req)
      2'b01: gnt_idx = 1'(REQ_CU);
      2'b10: gnt_idx = 1'(REQ_DMA);
      // tie: last == 1 means DMA went last, so CU wins
      2'b11: gnt_idx = last ? 1'(REQ_CU) : 1'(REQ_DMA);
      default: gnt_idx = 1'b0;
    endcase
    if (req != 2'b00)
      gnt = req_onehot(gnt_idx);
  end

endmodule

// File: rtl/swap_seq_ctrl.sv
// Sequences a three-step A<->B register swap over the shared bus via the swap register.
// Fixed 4-cycle request-to-done latency (1 when A==B); en=0 stalls in place with strobes masked.
module swap_seq_ctrl
  import swap_seq_ctrl_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      req,
  input  logic [AW-1:0]   a0_idx,
  input  logic [AW-1:0]   b0_idx,
  input  logic [AW-1:0]   a1_idx,
  input  logic [AW-1:0]   b1_idx,
  output logic [AW-1:0]   bus_sel,
  output logic            bus_tmp,
  output logic            swp2,
  output logic [NREG-1:0] ld_en,
  output logic [1:0]      gnt,
  output logic            busy,
  output logic            done
);

  state_t        state, state_nxt;
  logic          last_q, last_nxt;
  logic [AW-1:0] a_q, a_nxt;
  logic [AW-1:0] b_q, b_nxt;
  logic [1:0]    gnt_q, gnt_nxt;

  logic [1:0]    arb_gnt;
  logic          arb_idx;
  logic [AW-1:0] sel_a, sel_b;

  rr_arb2 u_arb (
    .req     (req),
    .last    (last_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    sel_a = arb_idx ? a1_idx : a0_idx;
    sel_b = arb_idx ? b1_idx : b0_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_q <= 1'b1;
      a_q    <= '0;
      b_q    <= '0;
      gnt_q  <= 2'b00;
    end else begin
      state  <= state_nxt;
      last_q <= last_nxt;
      a_q    <= a_nxt;
      b_q    <= b_nxt;
      gnt_q  <= gnt_nxt;
    end
  end

  // Requests are only looked at in IDLE, so anything that changes mid-operation is ignored.
  always_comb begin
    state_nxt = state;
    last_nxt  = last_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    gnt_nxt   = gnt_q;
    if (en) begin
      unique case (state)
        IDLE: begin
          if (req != 2'b00) begin
            gnt_nxt   = arb_gnt;
            last_nxt  = arb_idx;
            a_nxt     = sel_a;
            b_nxt     = sel_b;
            state_nxt = (sel_a == sel_b) ? DONE : SAVE;
          end
        end
        SAVE:    state_nxt = MOVE;
        MOVE:    state_nxt = RESTORE;
        RESTORE: state_nxt = DONE;
        DONE: begin
          state_nxt = IDLE;
          gnt_nxt   = 2'b00;
        end
        default: begin
          state_nxt = IDLE;
          gnt_nxt   = 2'b00;
        end
      endcase
    end
  end

  // Moore decode; load strobes and done are qualified by en so a stall never writes twice.
  always_comb begin
    bus_sel = '0;
    bus_tmp = 1'b0;
    swp2    = 1'b0;
    ld_en   = '0;
    gnt     = 2'b00;
    busy    = 1'b0;
    done    = 1'b0;
    if (!rst) begin
      gnt  = gnt_q;
      busy = (state != IDLE);
      unique case (state)
        IDLE: ;
        SAVE: begin
          bus_sel = a_q;
          swp2    = en;
        end
        MOVE: begin
          bus_sel    = b_q;
          ld_en[a_q] = en;
        end
        RESTORE: begin
          bus_tmp    = 1'b1;
          ld_en[b_q] = en;
        end
        DONE: done = en;
        default: ;
      endcase
    end
  end

  a_ld_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ld_en));
  a_swp_excl:  assert property (@(posedge clk) disable iff (rst) !(swp2 && (ld_en != '0)));
  a_gnt_oh:    assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

endmodule

// File: tb/tb_swap_seq_ctrl.sv
// Scoreboarded bench: driver pushes expected completions from a swap-level model, monitor pops on done.
module tb_swap_seq_ctrl;
  import swap_seq_ctrl_pkg::*;

  localparam int NREG = 16;
  localparam int AW   = 4;

  logic            clk = 1'b0;
  logic            rst, en;
  logic [1:0]      req;
  logic [AW-1:0]   a0_idx, b0_idx, a1_idx, b1_idx;
  logic [AW-1:0]   bus_sel;
  logic            bus_tmp, swp2, busy, done;
  logic [NREG-1:0] ld_en;
  logic [1:0]      gnt;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  swap_seq_ctrl #(.NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .a0_idx(a0_idx), .b0_idx(b0_idx), .a1_idx(a1_idx), .b1_idx(b1_idx),
    .bus_sel(bus_sel), .bus_tmp(bus_tmp), .swp2(swp2), .ld_en(ld_en),
    .gnt(gnt), .busy(busy), .done(done)
  );

  // Datapath around the controller: registers and swap register sample on negedge.
  logic [17:0] regs [NREG];
  logic [17:0] swp_reg;
  logic [17:0] dp_bus;
  initial forever begin
    @(negedge clk);
    dp_bus = bus_tmp ? swp_reg : regs[bus_sel];
    if (swp2) swp_reg = dp_bus;
    for (int i = 0; i < NREG; i++)
      if (ld_en[i]) regs[i] = dp_bus;
  end

  typedef struct {
    logic [1:0]  gnt;
    int          cyc;
    int          a;
    int          b;
    logic [17:0] va;
    logic [17:0] vb;
    logic [17:0] sw;
  } exp_t;

  exp_t sb_q[$];
  int n_chk = 0, n_fail = 0, n_done = 0, n_strobe = 0;

  // swap-level reference state
  logic [17:0] mem_m [NREG];
  logic [17:0] swp_m;
  logic        last_m;
  int          op_a [2][17];
  int          op_b [2][17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle invariants and scoreboard pop on every done pulse.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #3;
    if (rst) begin
      chk("rst_outputs", {bus_sel, bus_tmp, swp2, ld_en, gnt, busy, done}, 64'd0);
    end else begin
      chk("ld_en_onehot0", 64'($countones(ld_en) <= 1), 64'd1);
      chk("swp2_excl", 64'(swp2 && (ld_en != '0)), 64'd0);
      if (swp2 || ld_en != '0) n_strobe++;
      if (!en) chk("stall_strobes", {swp2, ld_en, done}, 64'd0);
      if (done) begin
        n_done++;
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 gnt=%b expected no completion (cycle %0d)", gnt, cyc);
        end else begin
          e = sb_q.pop_front();
          chk("done_gnt", gnt, e.gnt);
          chk("done_cycle", e.cyc == cyc ? 64'd0 : 64'(cyc), 64'd0);
          chk("reg_a", regs[e.a], e.va);
          chk("reg_b", regs[e.b], e.vb);
          chk("swap_reg", swp_reg, e.sw);
        end
      end else if (busy && sb_q.size() > 0) begin
        chk("gnt_held", gnt, sb_q[0].gnt);
      end
    end
  end

  task automatic set_idx(input int i, input int a, input int b);
    if (i == 0) begin
      a0_idx = AW'(a);
      b0_idx = AW'(b);
    end else begin
      a1_idx = AW'(b);
      a1_idx = AW'(a);
      b1_idx = AW'(b);
    end
  endtask

  // Runs ncu CU ops and ndma DMA ops (indices from op_a/op_b), each requester holding req until
  // its last done. Optional stall of the first op; optional early drop of the granted request.
  task automatic run_seq(input int ncu, input int ndma, input int stall_at, input int stall_len,
                         input bit drop_early);
    int   rem[2], opn[2], rem_m[2], opn_m[2];
    int   c0, t, w, a, b, budget;
    bit   first;
    logic [1:0] pend;
    exp_t e;

    c0 = cyc;
    t = c0;
    first = 1'b1;
    rem_m = '{ncu, ndma};
    opn_m = '{0, 0};
    while (rem_m[0] > 0 || rem_m[1] > 0) begin
      pend = {rem_m[1] > 0, rem_m[0] > 0};
      if (pend == 2'b11) w = last_m ? 0 : 1;
      else               w = pend[0] ? 0 : 1;
      a = op_a[w][opn_m[w]];
      b = op_b[w][opn_m[w]];
      e.gnt = (w == 1) ? 2'b10 : 2'b01;
      e.a = a;
      e.b = b;
      e.va = mem_m[b];
      e.vb = mem_m[a];
      if (a == b) begin
        e.sw = swp_m;
        e.cyc = t + 1;
      end else begin
        swp_m = mem_m[a];
        e.sw = swp_m;
        e.cyc = t + 4 + (first ? stall_len : 0);
        mem_m[a] = e.va;
        mem_m[b] = e.vb;
      end
      sb_q.push_back(e);
      last_m = (w == 1);
      t = e.cyc + 1;
      rem_m[w]--;
      opn_m[w]++;
      first = 1'b0;
    end

    rem = '{ncu, ndma};
    opn = '{0, 0};
    set_idx(0, op_a[0][0], op_b[0][0]);
    set_idx(1, op_a[1][0], op_b[1][0]);
    en = 1'b1;
    req = {rem[1] > 0, rem[0] > 0};
    budget = 0;
    while ((rem[0] > 0 || rem[1] > 0) && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
      for (int i = 0; i < 2; i++) begin
        if (done && gnt[i]) begin
          rem[i]--;
          opn[i]++;
          set_idx(i, op_a[i][opn[i]], op_b[i][opn[i]]);
        end else if (busy && gnt[i]) begin
          set_idx(i, $urandom_range(0, NREG-1), $urandom_range(0, NREG-1));
        end
      end
      en = !(stall_len > 0 && cyc >= c0 + stall_at && cyc < c0 + stall_at + stall_len);
      for (int i = 0; i < 2; i++)
        req[i] = (rem[i] > 0) && !(drop_early && busy && gnt[i] && !done);
    end
    if (budget >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL seq_timeout: got %0d/%0d ops left expected 0 after %0d cycles", rem[0], rem[1], budget);
      sb_q.delete();
    end
    en = 1'b1;
    req = 2'b00;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op(input int i, input int k, input bit distinct);
    int a;
    a = $urandom_range(0, NREG-1);
    op_a[i][k] = a;
    if (distinct)                         op_b[i][k] = (a + 1 + $urandom_range(0, NREG-2)) % NREG;
    else if ($urandom_range(0, 3) == 0)   op_b[i][k] = a;
    else                                  op_b[i][k] = $urandom_range(0, NREG-1);
  endtask

  initial begin
    int d0, s0, c0, ncu, ndma, sat, slen;
    rst = 1'b1;
    en = 1'b1;
    req = 2'b00;
    a0_idx = '0; b0_idx = '0; a1_idx = '0; b1_idx = '0;
    swp_reg = '0;
    swp_m = '0;
    last_m = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      regs[i] = 18'($urandom);
      mem_m[i] = regs[i];
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_after_rst", {bus_sel, bus_tmp, swp2, ld_en, gnt, busy, done}, 64'd0);

    // simultaneous requests from reset: CU first, DMA after one IDLE cycle
    rand_op(0, 0, 1'b1);
    rand_op(1, 0, 1'b1);
    d0 = n_done;
    run_seq(1, 1, 0, 0, 1'b0);
    chk("tie_done_count", 64'(n_done - d0), 64'd2);

    // persistent ties alternate 01,10,01,10
    for (int k = 0; k < 2; k++) begin
      rand_op(0, k, 1'b0);
      rand_op(1, k, 1'b0);
    end
    run_seq(2, 2, 0, 0, 1'b0);

    // directed swap R3 <-> R7
    regs[3] = 18'h00AAA;  mem_m[3] = 18'h00AAA;
    regs[7] = 18'h15555;  mem_m[7] = 18'h15555;
    op_a[0][0] = 3;
    op_b[0][0] = 7;
    run_seq(1, 0, 0, 0, 1'b0);

    // A == B short path: no strobes at all
    op_a[0][0] = 5;
    op_b[0][0] = 5;
    s0 = n_strobe;
    run_seq(1, 0, 0, 0, 1'b0);
    chk("same_idx_strobes", 64'(n_strobe - s0), 64'd0);

    // three-cycle stall in MOVE
    rand_op(0, 0, 1'b1);
    run_seq(1, 0, 2, 3, 1'b0);

    // reset during RESTORE aborts the swap after A was already written
    a0_idx = 4'd2;
    b0_idx = 4'd9;
    req = 2'b01;
    c0 = cyc;
    while (cyc < c0 + 3) begin
      @(posedge clk);
      #1;
    end
    chk("restore_reached", {bus_tmp, busy}, 64'd3);
    rst = 1'b1;
    req = 2'b00;
    swp_m = mem_m[2];
    mem_m[2] = mem_m[9];
    last_m = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", {bus_sel, bus_tmp, swp2, ld_en, gnt, busy, done}, 64'd0);
    rand_op(1, 0, 1'b1);
    run_seq(0, 1, 0, 0, 1'b0);

    // randomized mix
    for (int it = 0; it < 14; it++) begin
      ncu = $urandom_range(0, 2);
      ndma = $urandom_range(0, 2);
      if (ncu + ndma == 0) ncu = 1;
      sat = 0;
      slen = 0;
      for (int k = 0; k < 3; k++) begin
        rand_op(0, k, 1'b0);
        rand_op(1, k, 1'b0);
      end
      if (ncu + ndma == 1 && $urandom_range(0, 1) == 1) begin
        rand_op(ncu == 1 ? 0 : 1, 0, 1'b1);
        sat = $urandom_range(1, 3);
        slen = $urandom_range(1, 3);
      end
      run_seq(ncu, ndma, sat, slen, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/swap_seq_ctrl.md
SWAP_SEQ_CTRL -- requirements
Module: swap_seq_ctrl

Interface
REQ-001 Parameter NREG, default 16: number of 18-bit datapath registers on the shared bus.
REQ-002 Parameter AW, default 4: register index width; SHALL equal clog2(NREG).
REQ-003 clk  in  1  controller clock; all state updates on posedge; datapath registers sample on the following negedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 en  in  1  global enable; low = stall.
REQ-006 req  in  2  swap request, bit0 = control unit, bit1 = DMA; held high until done.
REQ-007 a0_idx, b0_idx, a1_idx, b1_idx  in  AW each  register pair to swap, per requester.
REQ-008 bus_sel  out  AW  index of the register driving the shared 18-bit bus.
REQ-009 bus_tmp  out  1  swap register drives the bus; overrides bus_sel.
REQ-010 swp2  out  1  load enable of the 18-bit swap register.
REQ-011 ld_en  out  NREG  one-hot load enable of the datapath registers.
REQ-012 gnt  out  2  one-hot grant, held for the whole operation.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle completion pulse to the granted requester.

Function
REQ-015 The FSM SHALL have states IDLE, SAVE, MOVE, RESTORE and DONE, with all outputs decoded from registered state (Moore).
REQ-016 In IDLE with en=1 and req!=0, the block SHALL grant one requester, latch its A/B indices and enter SAVE at the next posedge.
REQ-017 Arbitration SHALL be round-robin:
- a single request is granted;
- on simultaneous requests, the requester not granted last wins;
- the last-grant pointer resets to 1, so bit0 wins the first tie.
REQ-018 SAVE: bus_sel=A, swp2=1, ld_en=0; next state MOVE.
REQ-019 MOVE: bus_sel=B, ld_en[A]=1; next state RESTORE.
REQ-020 RESTORE: bus_tmp=1, ld_en[B]=1; next state DONE.
REQ-021 DONE: done=1, gnt still asserted, all load enables 0; next state IDLE.
REQ-022 Latency SHALL be fixed: a request sampled at posedge k gives SAVE in cycle k+1 and done in cycle k+4.
REQ-023 If the latched A equals B, the block SHALL go IDLE -> DONE directly and assert no load enables.
REQ-024 en=0 SHALL freeze the state, latched indices and pointer, and force swp2, ld_en and done to 0.
- bus_sel, bus_tmp, gnt and busy hold their values while stalled.
- The sequence resumes in the same state when en returns to 1.
REQ-025 Request changes after grant SHALL be ignored until IDLE; a dropped request does not abort the operation.
REQ-026 At most one bit of ld_en SHALL be high in any cycle, and swp2 SHALL never be high in the same cycle as any ld_en bit.
REQ-027 A request present in DONE SHALL be arbitrated only after the return to IDLE.
REQ-028 Back-to-back operations therefore have one IDLE cycle between them.

Reset
REQ-029 rst=1 SHALL force state IDLE, with priority over en, including mid-operation.
REQ-030 rst=1 SHALL force the last-grant pointer to 1 and the latched indices to 0.
REQ-031 During rst, all outputs SHALL be 0: bus_sel, bus_tmp, swp2, ld_en, gnt, busy, done.
REQ-032 A reset mid-operation SHALL NOT complete the swap; partial register contents are the requester's responsibility.

Structure
REQ-033 FSM state encoding, the NREG/AW defaults and requester index constants SHALL live in the shared processor package.
REQ-034 The round-robin arbiter SHALL be a sub-module, rr_arb2 (req, last pointer -> one-hot grant).
REQ-035 The one-hot ld_en decode SHALL stay inline.

Verification
REQ-036 req=01, a0=3, b0=7, R3=0x00AAA, R7=0x15555 -> gnt=01, done in cycle 4, then R3=0x15555, R7=0x00AAA, swap reg=0x00AAA.
REQ-037 req=11 from reset -> CU served first, DMA granted after one IDLE cycle, two done pulses in total.
REQ-038 Repeated simultaneous requests -> grants alternate 01,10,01,10.
REQ-039 a0=b0=5 -> done one cycle after the request, ld_en and swp2 stay 0, and R5 is unchanged.
REQ-040 en=0 for 3 cycles during MOVE -> state held, ld_en=0 while stalled, done delayed by exactly 3 cycles, final data correct.
REQ-041 rst asserted in RESTORE -> next cycle all outputs are 0 and the state is IDLE, and a following req=10 is granted normally.
